// File: rtl/sram_bank_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and sizes for the two-master SRAM bank arbiter.
//   ADDR_W : word address width (bank select in the top BANK_W bits)
//   DATA_W : data word width
//   BANK_W : bank-select bits, IDX_W : in-bank address bits
//   state_t: sequencer states, mid_t: master identifier
// -----------------------------------------------------------------------------
package sram_arb_pkg;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  localparam int BANK_W = 4;
  localparam int IDX_W  = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RDW  = 2'd2
  } state_t;

  typedef logic mid_t;
endpackage

// File: rtl/sram_bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_bank_arbiter_if
// Per-master request/response bundle.
//   req/we/addr/wdata : request side, driven by the master, held until gnt
//   gnt               : one-cycle pulse while the access is on the SRAM bus
//   rvalid/rdata      : read return, one-cycle pulse
// Modports: master (requester side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface sram_bank_arbiter_if;
  import sram_arb_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_bank_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
//   i_req[1:0] : request vector (bit n = master n)
//   i_last     : id of the most recent winner
//   o_gnt_id   : id of the chosen master (valid when o_any)
//   o_any      : at least one request present
// -----------------------------------------------------------------------------
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  mid_t       i_last,
  output mid_t       o_gnt_id,
  output logic       o_any
);
  always_comb begin
    o_any = |i_req;
    // On a tie the master that did not win last time goes next; otherwise
    // the sole requester wins (bit 1 alone selects master 1).
    if (i_req == 2'b11) o_gnt_id = ~i_last;
    else                o_gnt_id = i_req[1];
  end
endmodule

// File: rtl/sram_bank_arbiter.sv
// -----------------------------------------------------------------------------
// sram_bank_arbiter
// Round-robin arbiter / access sequencer putting single-word requests from
// two masters onto the shared SRAM address/WEN/CEN bus of the bank decoder.
//   clk, rst           : clock, synchronous active-high reset
//   m0, m1             : master request/response bundles (slave modport)
//   mem_A/mem_D        : address and write data to the decoder
//   mem_WEN/mem_CEN    : active-low write enable / chip enable
//   mem_Q              : bank-muxed read data, valid the cycle after a read
// Every output comes straight from a register.
// -----------------------------------------------------------------------------
module sram_bank_arbiter
  import sram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  sram_bank_arbiter_if.slave m0,
  sram_bank_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] mem_A,
  output logic              mem_WEN,
  output logic              mem_CEN,
  output logic [DATA_W-1:0] mem_D,
  input  logic [DATA_W-1:0] mem_Q
);
  logic [1:0]        w_req;
  logic [1:0]        w_we;
  logic [ADDR_W-1:0] w_addr  [2];
  logic [DATA_W-1:0] w_wdata [2];
  mid_t              w_win;
  logic              w_any;

  state_t            r_state,   w_state_next;
  mid_t              r_rr_last, w_rr_last_next;
  mid_t              r_id,      w_id_next;
  logic [ADDR_W-1:0] r_mem_a,   w_mem_a_next;
  logic [DATA_W-1:0] r_mem_d,   w_mem_d_next;
  logic              r_mem_wen, w_mem_wen_next;
  logic              r_mem_cen, w_mem_cen_next;
  logic [1:0]        r_gnt,     w_gnt_next;
  logic [1:0]        r_rvalid;
  logic [DATA_W-1:0] r_rdata [2];
  logic [1:0]        w_cap;

  assign w_req      = {m1.req, m0.req};
  assign w_we       = {m1.we, m0.we};
  assign w_addr[0]  = m0.addr;
  assign w_addr[1]  = m1.addr;
  assign w_wdata[0] = m0.wdata;
  assign w_wdata[1] = m1.wdata;

  rr_arb2 u_rr_arb2 (
    .i_req    (w_req),
    .i_last   (r_rr_last),
    .o_gnt_id (w_win),
    .o_any    (w_any)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    w_state_next   = r_state;
    w_rr_last_next = r_rr_last;
    w_id_next      = r_id;
    w_mem_a_next   = r_mem_a;
    w_mem_d_next   = r_mem_d;
    w_mem_wen_next = 1'b1;
    w_mem_cen_next = 1'b1;
    w_gnt_next     = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next      = ACC;
          w_rr_last_next    = w_win;
          w_id_next         = w_win;
          w_mem_a_next      = w_addr[w_win];
          w_mem_d_next      = w_wdata[w_win];
          w_mem_wen_next    = ~w_we[w_win];
          w_mem_cen_next    = 1'b0;
          w_gnt_next[w_win] = 1'b1;
        end
      end
      // WEN still high here means the access on the bus is a read.
      ACC:     w_state_next = r_mem_wen ? RDW : IDLE;
      RDW:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
      r_id      <= 1'b0;
      r_mem_a   <= '0;
      r_mem_d   <= '0;
      r_mem_wen <= 1'b1;
      r_mem_cen <= 1'b1;
      r_gnt     <= 2'b00;
    end else begin
      r_state   <= w_state_next;
      r_rr_last <= w_rr_last_next;
      r_id      <= w_id_next;
      r_mem_a   <= w_mem_a_next;
      r_mem_d   <= w_mem_d_next;
      r_mem_wen <= w_mem_wen_next;
      r_mem_cen <= w_mem_cen_next;
      r_gnt     <= w_gnt_next;
    end
  end

  // Read return path: mem_Q is live during RDW and is captured for the
  // remembered winner only; the other master's rdata is left untouched.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign w_cap[gi] = (r_state == RDW) && (r_id == mid_t'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rvalid[gi] <= 1'b0;
        r_rdata[gi]  <= '0;
      end else begin
        r_rvalid[gi] <= w_cap[gi];
        if (w_cap[gi]) r_rdata[gi] <= mem_Q;
      end
    end
  end

  assign m0.gnt    = r_gnt[0];
  assign m1.gnt    = r_gnt[1];
  assign m0.rvalid = r_rvalid[0];
  assign m1.rvalid = r_rvalid[1];
  assign m0.rdata  = r_rdata[0];
  assign m1.rdata  = r_rdata[1];
  assign mem_A     = r_mem_a;
  assign mem_D     = r_mem_d;
  assign mem_WEN   = r_mem_wen;
  assign mem_CEN   = r_mem_cen;
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_bank_arbiter
// Drives the arbiter from two master threads; read expectations come from a
// shadow memory written in each master's program order and are queued at
// issue time. A negedge monitor pops them when rvalid appears and checks bus
// contents and latency at each grant.
// -----------------------------------------------------------------------------
module tb_sram_bank_arbiter;
  import sram_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] mem_A;
  logic              mem_WEN, mem_CEN;
  logic [DATA_W-1:0] mem_D;
  logic [DATA_W-1:0] mem_Q = '0;

  sram_bank_arbiter_if m0_if ();
  sram_bank_arbiter_if m1_if ();

  sram_bank_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .mem_A   (mem_A),
    .mem_WEN (mem_WEN),
    .mem_CEN (mem_CEN),
    .mem_D   (mem_D),
    .mem_Q   (mem_Q)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] shadow    [logic [ADDR_W-1:0]];

  logic              drv_we    [2];
  logic [ADDR_W-1:0] drv_addr  [2];
  logic [DATA_W-1:0] drv_wdata [2];

  logic [DATA_W-1:0] exp0 [$];
  logic [DATA_W-1:0] exp1 [$];
  int lat0 [$];
  int lat1 [$];
  int g_id  [$];
  int g_cyc [$];

  always @(posedge clk) cyc++;

  // Behavioural SRAM: write on CEN/WEN low, read data appears next cycle.
  always @(posedge clk) begin
    if (!mem_CEN) begin
      if (!mem_WEN) mem_model[mem_A] = mem_D;
      else mem_Q <= mem_model.exists(mem_A) ? mem_model[mem_A] : '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] shadow_rd(input logic [ADDR_W-1:0] a);
    return shadow.exists(a) ? shadow[a] : '0;
  endfunction

  task automatic set_req(input int m, input bit r, input bit we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    drv_we[m] = we; drv_addr[m] = a; drv_wdata[m] = d;
    if (m == 0) begin m0_if.req = r; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d; end
    else        begin m1_if.req = r; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d; end
  endtask

  // One access: queue the expected read data, raise req, hold until gnt.
  task automatic do_op(input int m, input bit we,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit got = 1'b0;
    if (we) shadow[a] = d;
    else if (m == 0) exp0.push_back(shadow_rd(a));
    else             exp1.push_back(shadow_rd(a));
    set_req(m, 1'b1, we, a, d);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((m == 0) ? m0_if.gnt : m1_if.gnt) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL gnt_timeout m%0d addr 0x%0h", m, a);
    end
    @(posedge clk); #1;
    set_req(m, 1'b0, we, a, d);
  endtask

  // Monitor: bus contents at every grant, read data and latency at rvalid.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("cen_vs_gnt", {63'd0, mem_CEN}, {63'd0, ~(m0_if.gnt | m1_if.gnt)});
      if (m0_if.gnt && m1_if.gnt) chk("dual_gnt", 64'd1, 64'd0);
      for (int m = 0; m < 2; m++) begin
        if ((m == 0) ? m0_if.gnt : m1_if.gnt) begin
          $display("cyc %0d gnt m%0d %s A=0x%05h D=0x%08h", cyc, m,
                   drv_we[m] ? "WR" : "RD", mem_A, mem_D);
          g_id.push_back(m);
          g_cyc.push_back(cyc);
          chk("gnt_addr", {46'd0, mem_A}, {46'd0, drv_addr[m]});
          chk("gnt_wen", {63'd0, mem_WEN}, {63'd0, ~drv_we[m]});
          if (drv_we[m]) chk("gnt_wdata", {32'd0, mem_D}, {32'd0, drv_wdata[m]});
          else if (m == 0) lat0.push_back(cyc + 2);
          else             lat1.push_back(cyc + 2);
        end
      end
      if (m0_if.rvalid) begin
        $display("cyc %0d rvalid m0 Q=0x%08h", cyc, m0_if.rdata);
        if (exp0.size() == 0 || lat0.size() == 0) chk("m0_unexpected_rvalid", 64'd1, 64'd0);
        else begin
          chk("m0_rdata", {32'd0, m0_if.rdata}, {32'd0, exp0.pop_front()});
          chk("m0_latency", 64'(cyc), 64'(lat0.pop_front()));
        end
      end
      if (m1_if.rvalid) begin
        $display("cyc %0d rvalid m1 Q=0x%08h", cyc, m1_if.rdata);
        if (exp1.size() == 0 || lat1.size() == 0) chk("m1_unexpected_rvalid", 64'd1, 64'd0);
        else begin
          chk("m1_rdata", {32'd0, m1_if.rdata}, {32'd0, exp1.pop_front()});
          chk("m1_latency", 64'(cyc), 64'(lat1.pop_front()));
        end
      end
    end
  end

  initial begin
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cen", {63'd0, mem_CEN}, 64'd1);
    chk("rst_wen", {63'd0, mem_WEN}, 64'd1);
    chk("rst_addr", {46'd0, mem_A}, 64'd0);
    chk("rst_d", {32'd0, mem_D}, 64'd0);
    chk("rst_gnt", {62'd0, m1_if.gnt, m0_if.gnt}, 64'd0);
    chk("rst_rvalid", {62'd0, m1_if.rvalid, m0_if.rvalid}, 64'd0);
    chk("rst_rdata", {m1_if.rdata, m0_if.rdata}, 64'd0);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Single write, then cross-master readback.
    do_op(0, 1'b1, 18'h3C005, 32'hDEADBEEF);
    do_op(1, 1'b0, 18'h3C005, 32'h0);
    // Boundary addresses and data.
    do_op(0, 1'b1, 18'h00000, 32'h00000001);
    do_op(1, 1'b1, 18'h3FFFF, 32'hFFFFFFFF);
    do_op(0, 1'b0, 18'h3FFFF, 32'h0);
    do_op(1, 1'b0, 18'h00000, 32'h0);
    do_op(1, 1'b1, 18'h12345, 32'hA5A5_0001);
    repeat (4) @(posedge clk);

    // Both masters hold reads continuously: grants must alternate.
    g_id.delete();
    fork
      begin
        do_op(0, 1'b0, 18'h3C005, 32'h0);
        do_op(0, 1'b0, 18'h00000, 32'h0);
        do_op(0, 1'b0, 18'h3FFFF, 32'h0);
      end
      begin
        do_op(1, 1'b0, 18'h12345, 32'h0);
        do_op(1, 1'b0, 18'h3C005, 32'h0);
        do_op(1, 1'b0, 18'h00000, 32'h0);
      end
    join
    chk("rr_count", 64'(g_id.size()), 64'd6);
    for (int i = 0; i < 6 && i < g_id.size(); i++) chk("rr_order", 64'(g_id[i]), 64'(i % 2));
    repeat (4) @(posedge clk);

    // Reset in the read-data cycle of an m0 read.
    set_req(0, 1'b1, 1'b0, 18'h3C005, 32'h0);
    begin
      bit got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (m0_if.gnt) begin got = 1'b1; break; end
      end
      chk("rst_test_gnt", {63'd0, got}, 64'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 18'h3C005, 32'h0);
    lat0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid", {63'd0, m0_if.rvalid}, 64'd0);
    chk("midrst_cen", {63'd0, mem_CEN}, 64'd1);
    g_id.delete();
    fork
      do_op(0, 1'b0, 18'h00000, 32'h0);
      do_op(1, 1'b0, 18'h3FFFF, 32'h0);
    join
    chk("post_rst_first", (g_id.size() > 0) ? 64'(g_id[0]) : 64'd99, 64'd0);
    chk("post_rst_second", (g_id.size() > 1) ? 64'(g_id[1]) : 64'd99, 64'd1);
    repeat (4) @(posedge clk);

    // m1 back-to-back writes: grants two cycles apart.
    g_cyc.delete();
    for (int i = 0; i < 4; i++) do_op(1, 1'b1, 18'(18'h20000 + i), 32'(32'hC0DE0000 + i));
    chk("b2b_count", 64'(g_cyc.size()), 64'd4);
    for (int i = 1; i < 4 && i < g_cyc.size(); i++)
      chk("b2b_spacing", 64'(g_cyc[i] - g_cyc[i-1]), 64'd2);
    repeat (4) @(posedge clk);

    // Random concurrent traffic; each master owns addresses with bit0 = id.
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        do_op(0, 1'($urandom_range(0, 1)), {4'($urandom), 13'd0, 1'b0}, $urandom);
      end
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        do_op(1, 1'($urandom_range(0, 1)), {4'($urandom), 13'd0, 1'b1}, $urandom);
      end
    join
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drain_m0", 64'(exp0.size()), 64'd0);
    chk("drain_m1", 64'(exp1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
